// File: rtl/score_seg_scan_if.sv
// -----------------------------------------------------------------------------
// score_seg_scan_if
// Bundles the score display engine's load handshake and display pins.
//   value       : binary score offered for display (master -> slave)
//   value_valid : one-cycle load strobe, value sampled on the same edge
//   busy        : conversion in progress (slave -> master)
//   overflow    : last committed value did not fit in DIGITS decimal digits
//   shift       : active-low digit enables, bit 0 = rightmost digit
//   oData       : active-low segments, bit 0 = a ... bit 6 = g
// Modports: master (score source / bench), slave (score_seg_scan).
// -----------------------------------------------------------------------------
interface score_seg_scan_if #(
  parameter int DIGITS  = 8,
  parameter int VALUE_W = 32
);
  logic [VALUE_W-1:0] value;
  logic               value_valid;
  logic               busy;
  logic               overflow;
  logic [DIGITS-1:0]  shift;
  logic [6:0]         oData;

  modport master (output value, value_valid, input busy, overflow, shift, oData);
  modport slave  (input value, value_valid, output busy, overflow, shift, oData);
endinterface

// File: rtl/score_seg_scan.sv
// -----------------------------------------------------------------------------
// score_seg_scan
// Converts a binary score into packed BCD with an iterative double-dabble
// engine (one bit per clock), then time-multiplexes DIGITS seven-segment
// digits using an internal scan prescaler. A one-deep pending buffer keeps
// the most recent strobe that arrives while a conversion is running.
// Ports:
//   clk : system clock (single domain)
//   rst : asynchronous, active-low reset
//   bus : score_seg_scan_if.slave (value/value_valid in; busy, overflow,
//         shift, oData out; all outputs registered)
// Optional feature: define SCORE_LZB_EN to blank leading-zero digits
// (digit 0 is always shown, overflow dashes take precedence).
// -----------------------------------------------------------------------------
module score_seg_scan #(
  parameter int DIGITS   = 8,
  parameter int VALUE_W  = 32,
  parameter int SCAN_DIV = 100000
) (
  input logic            clk,
  input logic            rst,
  score_seg_scan_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [VALUE_W-1:0] bin_r, pend_val_r, load_val_s;
  logic               pend_r, load_s;
  logic [BCD_W-1:0]   bcd_r, disp_r, bcd_adj_s;
  logic               ovf_acc_r, ovf_r, busy_r;
  logic [CNT_W-1:0]   iter_r;
  logic [PRE_W-1:0]   pre_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DIGITS-1:0]  shift_r;
  logic [6:0]         odata_r, seg_s;
  logic [3:0]         nib_s;
  logic               blank_s;

  // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = b[4*i +: 4];
    end
    return r;
  endfunction

  // Active-low segment pattern; non-decimal nibbles are blanked.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign bcd_adj_s = dd_adjust(bcd_r);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // FSM next state: COMMIT re-enters CONV when a value is waiting.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.value_valid) state_s = CONV; else state_s = IDLE;
      CONV:    if (iter_r == CNT_W'(VALUE_W - 1)) state_s = COMMIT; else state_s = CONV;
      COMMIT:  if (pend_r || bus.value_valid) state_s = CONV; else state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Conversion start: an IDLE strobe, or at COMMIT the pending value
  // (a strobe landing on COMMIT with nothing pending is taken directly).
  always_comb begin
    load_s     = 1'b0;
    load_val_s = bus.value;
    case (state_r)
      IDLE: begin
        if (bus.value_valid) load_s = 1'b1;
        else                 load_s = 1'b0;
      end
      COMMIT: begin
        if (pend_r) begin
          load_s     = 1'b1;
          load_val_s = pend_val_r;
        end else if (bus.value_valid) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
  end

  // Double-dabble datapath, commit into the display register, busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_r     <= '0;
      bcd_r     <= '0;
      ovf_acc_r <= 1'b0;
      iter_r    <= '0;
      disp_r    <= '0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (load_s) begin
        bin_r     <= load_val_s;
        bcd_r     <= '0;
        ovf_acc_r <= 1'b0;
        iter_r    <= '0;
      end else if (state_r == CONV) begin
        bin_r     <= bin_r << 1;
        bcd_r     <= {bcd_adj_s[BCD_W-2:0], bin_r[VALUE_W-1]};
        // A carry out of the top nibble means the value needs more digits.
        ovf_acc_r <= ovf_acc_r | bcd_adj_s[BCD_W-1];
        iter_r    <= iter_r + CNT_W'(1);
      end
      if (state_r == COMMIT) begin
        disp_r <= bcd_r;
        ovf_r  <= ovf_acc_r;
      end
      busy_r <= (state_s != IDLE);
    end
  end

  // One-deep pending buffer; the latest strobe during a conversion wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_val_r <= '0;
      pend_r     <= 1'b0;
    end else if (bus.value_valid &&
                 ((state_r == CONV) || ((state_r == COMMIT) && pend_r))) begin
      pend_val_r <= bus.value;
      pend_r     <= 1'b1;
    end else if (state_r == COMMIT) begin
      pend_r <= 1'b0;
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= '0;
      idx_r <= '0;
    end else if (pre_r == PRE_W'(SCAN_DIV - 1)) begin
      pre_r <= '0;
      if (idx_r == IDX_W'(DIGITS - 1)) idx_r <= '0;
      else                             idx_r <= idx_r + IDX_W'(1);
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  // Segment selection for the currently scanned digit.
  always_comb begin
    nib_s = disp_r[{idx_r, 2'b00} +: 4];
`ifdef SCORE_LZB_EN
    // Blank when this digit and every digit above it are zero.
    blank_s = (idx_r != '0) && ((disp_r >> {idx_r, 2'b00}) == '0);
`else
    blank_s = 1'b0;
`endif
    if (ovf_r)        seg_s = 7'h3F;
    else if (blank_s) seg_s = 7'h7F;
    else              seg_s = seg7(nib_s);
  end

  // Registered display pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= '1;
      odata_r <= 7'h7F;
    end else begin
      shift_r <= ~(DIGITS'(1) << idx_r);
      odata_r <= seg_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.overflow = ovf_r;
  assign bus.shift    = shift_r;
  assign bus.oData    = odata_r;

endmodule

// File: tb/tb_score_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_score_seg_scan
// Scoreboard bench for score_seg_scan (DIGITS=4, VALUE_W=16, SCAN_DIV=4).
// Each strobe that should reach the display pushes {value, commit cycle};
// a monitor pops it at that cycle, checks overflow/busy, and from then on
// checks every scanned digit against a decimal reference model.
// -----------------------------------------------------------------------------
module tb_score_seg_scan;
  localparam int DIGITS   = 4;
  localparam int VALUE_W  = 16;
  localparam int SCAN_DIV = 4;

  typedef struct {
    int unsigned val;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_seg_scan_if #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) bus ();

  score_seg_scan #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  exp_t        sb_q[$];
  int unsigned disp_val = 0;
  int unsigned disp_from = 0;
  int          busy_run = 0;
  int          last_busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference segment pattern for digit idx of a committed value.
  function automatic logic [6:0] ref_seg(input int unsigned v, input int idx);
    int unsigned p = 1;
    int unsigned d;
    if (v >= 10000) return 7'h3F;
    for (int k = 0; k < idx; k++) p = p * 10;
    d = (v / p) % 10;
`ifdef SCORE_LZB_EN
    if (idx != 0 && v < p) return 7'h7F;
`endif
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Monitor: busy run length, scoreboard pops, per-digit display checks.
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_run = 0;
      end else begin
        if (bus.busy) busy_run++;
        else if (busy_run != 0) begin
          last_busy_run = busy_run;
          busy_run = 0;
        end
        if (sb_q.size() != 0 && cyc > sb_q[0].at) begin
          check_val("commit_missed", cyc, sb_q[0].at);
          void'(sb_q.pop_front());
        end
        if (sb_q.size() != 0 && cyc == sb_q[0].at) begin
          e = sb_q.pop_front();
          check_val("overflow", {31'd0, bus.overflow}, {31'd0, (e.val >= 10000)});
          check_val("busy_after_commit", {31'd0, bus.busy}, {31'd0, (sb_q.size() != 0)});
          disp_val  = e.val;
          disp_from = cyc + 1;
        end
        if (cyc >= disp_from && bus.shift != 4'hF) begin
          idx = 0;
          for (int k = 0; k < DIGITS; k++) if (!bus.shift[k]) idx = k;
          check_val("shift_onehot", $countones(~bus.shift), 1);
          check_val("seg", {25'd0, bus.oData}, {25'd0, ref_seg(disp_val, idx)});
        end
      end
    end
  end

  task automatic strobe(input int unsigned v, input bit push, input int unsigned at);
    logic [31:0] v32;
    v32 = v;
    bus.value       = v32[15:0];
    bus.value_valid = 1'b1;
    if (push) sb_q.push_back('{val: v, at: at});
    @(negedge clk);
    bus.value_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_bound", {31'd0, (n < 300)}, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int unsigned t0;
    logic [3:0]  one;
    one             = 4'b0001;
    bus.value       = '0;
    bus.value_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check_val("rst_shift", {28'd0, bus.shift}, 32'hF);
    check_val("rst_odata", {25'd0, bus.oData}, 32'h7F);
    rst = 1'b1;

    // Scan order and dwell after release.
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check_val("scan_shift", {28'd0, bus.shift}, {28'd0, ~(one << (j / 4))});
    end

    strobe(1234, 1'b1, cyc + 18);
    wait_done();
    check_val("busy_len_1234", last_busy_run, 17);

    strobe(9999, 1'b1, cyc + 18);
    wait_done();
    strobe(10000, 1'b1, cyc + 18);
    wait_done();
    check_val("ovf_10000", {31'd0, bus.overflow}, 32'd1);

    // Asynchronous reset in the middle of a conversion.
    strobe(4321, 1'b0, 0);
    repeat (7) @(negedge clk);
    check_val("busy_mid_conv", {31'd0, bus.busy}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check_val("arst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("arst_ovf", {31'd0, bus.overflow}, 32'd0);
    check_val("arst_shift", {28'd0, bus.shift}, 32'hF);
    check_val("arst_odata", {25'd0, bus.oData}, 32'h7F);
    sb_q.delete();
    disp_val  = 0;
    disp_from = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_val("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    // Pending buffer: 42 is overwritten by 77 before the first commit.
    t0 = cyc;
    strobe(5, 1'b1, t0 + 18);
    repeat (2) @(negedge clk);
    strobe(42, 1'b0, 0);
    strobe(77, 1'b1, t0 + 35);
    wait_done();
    check_val("busy_len_pend", last_busy_run, 34);

    // Strobe landing exactly on the commit edge.
    t0 = cyc;
    strobe(100, 1'b1, t0 + 18);
    while (cyc < t0 + 17) @(negedge clk);
    strobe(200, 1'b1, cyc + 18);
    wait_done();
    check_val("busy_len_edge", last_busy_run, 34);

    for (int r = 0; r < 3; r++) begin
      strobe($urandom_range(0, 12000), 1'b1, cyc + 18);
      wait_done();
    end

`ifdef SCORE_LZB_EN
    strobe(7, 1'b1, cyc + 18);
    wait_done();
`endif

    strobe(0, 1'b1, cyc + 18);
    wait_done();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
